// File: rtl/hog_pkg.sv
// Shared constants, histogram type and packing helper for the HOG cell histogram block.
package hog_pkg;

  localparam int NUM_BINS = 9;
  localparam int BIN_W    = 32;
  localparam int CELL_SZ  = 8;
  localparam int ADDR_W   = 13;
  localparam int HIST_W   = NUM_BINS * BIN_W;

  typedef logic [NUM_BINS-1:0][BIN_W-1:0] hist_t;

  // Bin 0 lands on the least significant 32 bits of the output word.
  function automatic logic [HIST_W-1:0] pack_hist(input hist_t h);
    logic [HIST_W-1:0] v;
    v = '0;
    for (int k = 0; k < NUM_BINS; k++) begin
      v[k*BIN_W +: BIN_W] = h[k];
    end
    return v;
  endfunction

endpackage

// File: rtl/hog_cell_hist_if.sv
// Pixel-in / histogram-out bundle for hog_cell_hist.
// Carries i_sof only when HOG_CELL_HIST_SOF_EN is defined.
interface hog_cell_hist_if #(
    parameter int MAG_W  = 16,
    parameter int DATA_W = 288
);
    import hog_pkg::*;

    logic                 i_valid;
    logic [MAG_W-1:0]     i_mag;
    logic [3:0]           i_bin;
`ifdef HOG_CELL_HIST_SOF_EN
    logic                 i_sof;
`endif
    logic [DATA_W-1:0]    bin;
    logic                 o_valid;
    logic [ADDR_W-1:0]    addr_fw;

`ifdef HOG_CELL_HIST_SOF_EN
    modport master (output i_valid, i_mag, i_bin, i_sof, input bin, o_valid, addr_fw);
    modport slave  (input i_valid, i_mag, i_bin, i_sof, output bin, o_valid, addr_fw);
`else
    modport master (output i_valid, i_mag, i_bin, input bin, o_valid, addr_fw);
    modport slave  (input i_valid, i_mag, i_bin, output bin, o_valid, addr_fw);
`endif

endinterface

// File: rtl/hog_cell_acc_mem.sv
// One histogram entry per cell column: combinational read, write on posedge.
module hog_cell_acc_mem
    import hog_pkg::*;
#(
    parameter int ENTRIES = 80,
    parameter int IDX_W   = 7
) (
    input  logic             clk,
    input  logic [IDX_W-1:0] rd_idx,
    output hist_t            rd_data,
    input  logic             wr_en,
    input  logic [IDX_W-1:0] wr_idx,
    input  hist_t            wr_data
);

    hist_t mem [ENTRIES];

    assign rd_data = mem[rd_idx];

    // NOTE: the array has no reset; every entry is rebuilt by its cell's first-pixel overwrite.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_idx] <= wr_data;
        end
    end

endmodule

// File: rtl/hog_cell_hist.sv
// Raster-stream 8x8-cell, 9-bin gradient histogram accumulator.
// Optional frame-start input enabled by defining HOG_CELL_HIST_SOF_EN.
module hog_cell_hist
    import hog_pkg::*;
#(
    parameter int CELLS_PER_ROW = 80,
    parameter int CELL_ROWS     = 60,
    parameter int MAG_W         = 16,
    parameter int DATA_W        = 288
) (
    input  logic          clk,
    input  logic          rst,
    hog_cell_hist_if.slave px_if
);

    localparam int IDX_W  = (CELLS_PER_ROW > 1) ? $clog2(CELLS_PER_ROW) : 1;
    localparam int CY_W   = (CELL_ROWS > 1) ? $clog2(CELL_ROWS) : 1;
    localparam int PX_W   = IDX_W + 3;
    localparam int PY_W   = CY_W + 3;
    localparam int PX_MAX = CELL_SZ * CELLS_PER_ROW - 1;
    localparam int PY_MAX = CELL_SZ * CELL_ROWS - 1;

    logic [PX_W-1:0]   px_q, px_cur, px_nxt;
    logic [PY_W-1:0]   py_q, py_cur, py_nxt;

    // Registered pixel: the read-modify-write happens one cycle after sampling.
    logic              s_valid;
    logic [MAG_W-1:0]  s_mag;
    logic [3:0]        s_bin;
    logic [IDX_W-1:0]  s_cx;
    logic [CY_W-1:0]   s_cy;
    logic              s_first;
    logic              s_last;

    hist_t             acc_rd, acc_upd, hist_q;
    logic [ADDR_W-1:0] addr_q, addr_nxt;
    logic              o_valid_q;

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        px_cur = px_q;
        py_cur = py_q;
`ifdef HOG_CELL_HIST_SOF_EN
        if (px_if.i_sof) begin
            px_cur = '0;
            py_cur = '0;
        end
`endif
        px_nxt = (px_cur == PX_W'(PX_MAX)) ? '0 : px_cur + 1'b1;
        py_nxt = py_cur;
        if (px_cur == PX_W'(PX_MAX)) begin
            py_nxt = (py_cur == PY_W'(PY_MAX)) ? '0 : py_cur + 1'b1;
        end
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            px_q    <= '0;
            py_q    <= '0;
            s_valid <= 1'b0;
            s_mag   <= '0;
            s_bin   <= '0;
            s_cx    <= '0;
            s_cy    <= '0;
            s_first <= 1'b0;
            s_last  <= 1'b0;
        end else begin
            s_valid <= px_if.i_valid;
            if (px_if.i_valid) begin
                px_q    <= px_nxt;
                py_q    <= py_nxt;
                s_mag   <= px_if.i_mag;
                s_bin   <= px_if.i_bin;
                s_cx    <= px_cur[PX_W-1:3];
                s_cy    <= py_cur[PY_W-1:3];
                s_first <= (px_cur[2:0] == 3'd0) && (py_cur[2:0] == 3'd0);
                s_last  <= (px_cur[2:0] == 3'd7) && (py_cur[2:0] == 3'd7);
            end
        end
    end

    hog_cell_acc_mem #(
        .ENTRIES (CELLS_PER_ROW),
        .IDX_W   (IDX_W)
    ) u_acc_mem (
        .clk     (clk),
        .rd_idx  (s_cx),
        .rd_data (acc_rd),
        .wr_en   (s_valid),
        .wr_idx  (s_cx),
        .wr_data (acc_upd)
    );

    // Bin indices above 8 match no k, so such pixels contribute nothing.
    always_comb begin
        acc_upd = s_first ? '0 : acc_rd;
        for (int k = 0; k < NUM_BINS; k++) begin
            if (s_bin == 4'(k)) begin
                acc_upd[k] = acc_upd[k] + BIN_W'(s_mag);
            end
        end
    end

    assign addr_nxt = ADDR_W'(s_cy) * ADDR_W'(CELLS_PER_ROW) + ADDR_W'(s_cx);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hist_q    <= '0;
            addr_q    <= '0;
            o_valid_q <= 1'b0;
        end else begin
            o_valid_q <= 1'b0;
            if (s_valid && s_last) begin
                hist_q    <= acc_upd;
                addr_q    <= addr_nxt;
                o_valid_q <= 1'b1;
            end
        end
    end

    assign px_if.bin     = DATA_W'(pack_hist(hist_q));
    assign px_if.addr_fw = addr_q;
    assign px_if.o_valid = o_valid_q;

endmodule

// File: tb/tb_hog_cell_hist.sv
// Directed bench for hog_cell_hist on a 2x2-cell (16x16 pixel) frame.
module tb_hog_cell_hist;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    hog_cell_hist_if #(.MAG_W(16), .DATA_W(288)) hif ();

    hog_cell_hist #(
        .CELLS_PER_ROW (2),
        .CELL_ROWS     (2),
        .MAG_W         (16),
        .DATA_W        (288)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .px_if (hif)
    );

    int checks = 0;
    int errors = 0;

    logic          smp_valid;
    logic [287:0]  smp_bin;
    logic [12:0]   smp_addr;
    logic [287:0]  obs_bin [$];
    logic [12:0]   obs_addr [$];
    logic [287:0]  exp_bin [$];
    logic [12:0]   exp_addr [$];

    // Reference model state: raster position and one histogram per cell.
    int            tpx = 0;
    int            tpy = 0;
    logic [287:0]  m [4];

    task automatic check(input string tag, input logic [287:0] obs, input logic [287:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_pixel(input logic [15:0] mag, input logic [3:0] b, input logic sof);
        int a;
        int bi;
        if (sof) begin
            tpx = 0;
            tpy = 0;
        end
        a  = (tpy / 8) * 2 + (tpx / 8);
        bi = int'(b);
        if ((tpx % 8 == 0) && (tpy % 8 == 0)) m[a] = '0;
        if (bi <= 8) m[a][32*bi +: 32] = m[a][32*bi +: 32] + 32'(mag);
        if ((tpx % 8 == 7) && (tpy % 8 == 7)) begin
            exp_bin.push_back(m[a]);
            exp_addr.push_back(13'(a));
        end
        if (tpx == 15) begin
            tpx = 0;
            tpy = (tpy == 15) ? 0 : tpy + 1;
        end else begin
            tpx = tpx + 1;
        end
    endtask

    // Sample outputs on the falling edge, then drive the next input cycle.
    task automatic tick(input logic v, input logic [15:0] mag, input logic [3:0] b, input logic sof);
        @(negedge clk);
        smp_valid = hif.o_valid;
        smp_bin   = hif.bin;
        smp_addr  = hif.addr_fw;
        if (smp_valid) begin
            obs_bin.push_back(smp_bin);
            obs_addr.push_back(smp_addr);
        end
        hif.i_valid = v;
        hif.i_mag   = mag;
        hif.i_bin   = b;
`ifdef HOG_CELL_HIST_SOF_EN
        hif.i_sof   = sof;
`endif
        if (v) model_pixel(mag, b, sof);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick(1'b0, 16'h0, 4'h0, 1'b0);
    endtask

    task automatic clear_queues();
        obs_bin.delete();
        obs_addr.delete();
        exp_bin.delete();
        exp_addr.delete();
    endtask

    task automatic compare_queues(input string tag);
        check({tag, "_count"}, 288'(obs_bin.size()), 288'(exp_bin.size()));
        for (int k = 0; k < exp_bin.size(); k++) begin
            if (k < obs_bin.size()) begin
                check($sformatf("%s_addr%0d", tag, k), 288'(obs_addr[k]), 288'(exp_addr[k]));
                check($sformatf("%s_bin%0d", tag, k), obs_bin[k], exp_bin[k]);
            end
        end
    endtask

    task automatic compare_const(input string tag, input logic [287:0] exp);
        check({tag, "_count"}, 288'(obs_bin.size()), 288'(4));
        for (int k = 0; k < 4; k++) begin
            if (k < obs_bin.size()) begin
                check($sformatf("%s_addr%0d", tag, k), 288'(obs_addr[k]), 288'(k));
                check($sformatf("%s_bin%0d", tag, k), obs_bin[k], exp);
            end
        end
    endtask

    initial begin
        logic [287:0] c_const;
        logic [287:0] c_max;
        logic [287:0] c_sof;
        logic [287:0] last_bin;
        logic [15:0]  mag;
        logic [3:0]   b;

        c_const = 288'd64 << 96;
        c_max   = 288'h003F_FFC0 << 256;
        c_sof   = 288'd448 << 64;

        hif.i_valid = 1'b0;
        hif.i_mag   = '0;
        hif.i_bin   = '0;
`ifdef HOG_CELL_HIST_SOF_EN
        hif.i_sof   = 1'b0;
`endif

        // Reset state.
        repeat (3) @(negedge clk);
        check("rst_o_valid", 288'(hif.o_valid), 288'(0));
        check("rst_bin", hif.bin, 288'(0));
        check("rst_addr", 288'(hif.addr_fw), 288'(0));
        rst = 1'b1;

        // Constant stream: every cell gets bin3 = 64.
        clear_queues();
        for (int i = 0; i < 256; i++) tick(1'b1, 16'd1, 4'd3, 1'b0);
        idle(3);
        compare_const("const", c_const);

        // Max magnitude in bin 8, with a latency probe on cell 0's last pixel.
        clear_queues();
        for (int i = 0; i < 120; i++) tick(1'b1, 16'hFFFF, 4'd8, 1'b0);
        tick(1'b0, 16'h0, 4'h0, 1'b0);
        check("lat_edge_n", 288'(smp_valid), 288'(0));
        tick(1'b0, 16'h0, 4'h0, 1'b0);
        check("lat_edge_n1", 288'(smp_valid), 288'(1));
        check("lat_bin", smp_bin, c_max);
        tick(1'b0, 16'h0, 4'h0, 1'b0);
        check("lat_pulse_end", 288'(smp_valid), 288'(0));
        for (int i = 120; i < 256; i++) tick(1'b1, 16'hFFFF, 4'd8, 1'b0);
        idle(3);
        compare_const("maxmag", c_max);

        // Random bubbles (with garbage inputs) and invalid bins.
        clear_queues();
        for (int i = 0; i < 256; i++) begin
            repeat ($urandom_range(0, 2)) tick(1'b0, 16'($urandom), 4'($urandom), 1'b0);
            mag = 16'($urandom_range(0, 65535));
            b   = ($urandom_range(0, 4) == 0) ? 4'd15 : 4'($urandom_range(0, 8));
            tick(1'b1, mag, b, 1'b0);
        end
        idle(3);
        compare_queues("bubble");
        last_bin = (obs_bin.size() > 0) ? obs_bin[obs_bin.size()-1] : '0;
        idle(4);
        check("hold_valid", 288'(smp_valid), 288'(0));
        check("hold_bin", smp_bin, exp_bin[exp_bin.size()-1]);
        check("hold_bin_last", smp_bin, last_bin);
        check("hold_addr", 288'(smp_addr), 288'(3));

        // Two frames with different ramps: no residue, addresses restart.
        clear_queues();
        for (int i = 0; i < 256; i++) tick(1'b1, 16'(i & 255), 4'((i / 3) % 9), 1'b0);
        for (int i = 0; i < 256; i++) tick(1'b1, 16'(1000 - 3 * i), 4'((i * 5) % 9), 1'b0);
        idle(3);
        compare_queues("wrap");
        if (obs_addr.size() > 4) check("wrap_addr_restart", 288'(obs_addr[4]), 288'(0));

        // Reset in the middle of cell 0, just after pixel (5,3).
        for (int i = 0; i < 54; i++) tick(1'b1, 16'd500, 4'(i % 9), 1'b0);
        @(negedge clk);
        hif.i_valid = 1'b0;
        #2 rst = 1'b0;
        #1;
        check("arst_o_valid", 288'(hif.o_valid), 288'(0));
        check("arst_bin", hif.bin, 288'(0));
        check("arst_addr", 288'(hif.addr_fw), 288'(0));
        repeat (2) @(negedge clk);
        rst = 1'b1;
        tpx = 0;
        tpy = 0;
        clear_queues();
        for (int i = 0; i < 256; i++) tick(1'b1, 16'((i % 7) + 1), 4'(i % 11), 1'b0);
        idle(3);
        compare_queues("rstmid");
        if (obs_addr.size() > 0) check("rstmid_first_addr", 288'(obs_addr[0]), 288'(0));

`ifdef HOG_CELL_HIST_SOF_EN
        // Frame start at pixel 100: partial cells are dropped, counting restarts.
        clear_queues();
        for (int i = 0; i < 100; i++) tick(1'b1, 16'd9, 4'd1, 1'b0);
        tick(1'b1, 16'd7, 4'd2, 1'b1);
        for (int i = 1; i < 256; i++) tick(1'b1, 16'd7, 4'd2, 1'b0);
        idle(3);
        compare_const("sof", c_sof);
        compare_queues("sof_model");
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
